pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Central pipeline controller for the 5-stage core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences exception/ERET flushes: drives flush and new_pc.
- Keeps a stall-cycle performance counter and a stall watchdog.

Parameters:
- EXC_VECTOR, 32'h00000020, handler entry PC for all exceptions other than ERET.
- STALL_TIMEOUT, 1024, number of consecutive stalled cycles that sets the watchdog flag; minimum 2.
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low; reset when rst==0 at posedge clk.
- stallreq_from_if  in  1  instruction-bus wait.
- stallreq_from_id  in  1  load-use hazard.
- stallreq_from_ex  in  1  multi-cycle ALU (div/madd) busy.
- stallreq_from_mem  in  1  data-bus wait.
- excepttype_i  in  32  final exception type from the MEM stage; 0 means none.
- cp0_epc_i  in  32  EPC (forwarded) from CP0.
- stall  out  6  bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold.
- flush  out  1  clear all pipeline registers this edge.
- new_pc  out  32  redirect PC, valid while flush==1.
- stall_cycles  out  CNT_W  saturating count of cycles with stall!=0.
- stall_timeout  out  1  sticky watchdog flag.
- busy_recover  out  1  high in the RECOVER state.

Behaviour:
- Reset (rst==0 at posedge): state=RUN, stall_cycles=0, stall_timeout=0, run-length counter=0. While rst==0, outputs are forced to stall=0, flush=0, new_pc=0, busy_recover=0. Reset mid-flush or mid-stall aborts immediately.
- States: RUN, RECOVER.
- Outputs are Mealy: combinational from state and inputs, so pipeline registers act on the same edge.
- RUN, excepttype_i != 0:
  - flush=1, stall=6'b000000.
  - new_pc = cp0_epc_i if excepttype_i==32'h0000000e (ERET), else EXC_VECTOR.
  - Next state is RECOVER.
  - An exception has priority over every stall request in the same cycle.
- RUN, excepttype_i==0: flush=0, new_pc=0. stall is chosen by strict priority mem > ex > id > if:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- RECOVER:
  - Lasts exactly one cycle; flush=0, stall=0, busy_recover=1.
  - excepttype_i and stall requests are ignored, because MEM still holds flushed state.
  - Next state is always RUN.
- stall_cycles: increments by 1 on each posedge where the stall output is non-zero. It saturates at all-ones and never wraps.
- Watchdog run-length counter (width clog2(STALL_TIMEOUT)+1):
  - Increments while the stall output is non-zero; clears to 0 on any cycle with stall==0 or flush==1.
  - When it reaches STALL_TIMEOUT-1 and the stall output is non-zero, stall_timeout is set to 1. It stays set until reset.
- Combinational cross-check: stall may be non-zero only when flush==0.
- Stall-vector invariant: bit k set implies bits 0..k-1 are also set.

Decomposition:
- Shared defines package, alongside the existing Stop/NoStop and RstEnable definitions:
  - stall-vector constants STALL_IF, STALL_ID, STALL_EX, STALL_MEM, STALL_NONE
  - EXCTYPE_ERET, 32'h0000000e
  - state encodings CTRL_RUN, CTRL_RECOVER
- One sub-module is natural: stall_prio_enc, a purely combinational priority encoder from 4 requests to the 6-bit vector.
- The FSM, counters and watchdog stay in pipe_ctrl.

Test Plan:
- Reset/stall priority: hold rst=0 for 3 cycles, then release and assert all four requests together. Expect stall=6'b011111 and flush=0. Drop mem: expect 6'b001111. Drop ex: expect 6'b000111. Drop id: expect 6'b000011.
- Syscall: with excepttype_i=32'h8 and stallreq_from_ex=1 in the same cycle, expect flush=1, stall=0 and new_pc=32'h20. Next cycle, with excepttype_i still 8, expect busy_recover=1 and flush=0. The cycle after that, flush=1 again.
- ERET: cp0_epc_i=32'hBFC00100, excepttype_i=32'he. Expect new_pc=32'hBFC00100 and flush=1 for one cycle.
- Counter: assert stallreq_from_id for 5 cycles, then 2 idle cycles, then stallreq_from_if for 3 cycles. Expect stall_cycles=8. A flush cycle does not increment it.
- Watchdog (STALL_TIMEOUT=8):
  - stallreq_from_mem held 7 cycles → stall_timeout=0; 1 idle cycle; held 8 cycles → stall_timeout=1 after the 8th edge; it stays 1 after requests drop.
  - Separately, 5 stalled cycles, then an exception, then 7 stalled cycles → stall_timeout stays 0, because the flush clears the run-length counter.
- Mid-operation reset: in RECOVER with stall_cycles=3, drive rst=0 for 1 cycle. Expect state=RUN, stall_cycles=0, stall_timeout=0 and all outputs 0 during reset.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared pipeline-control defines: stall vectors, exception codes, controller states
package pipe_ctrl_pkg;

  localparam logic RST_ENABLE  = 1'b0;
  localparam logic RST_DISABLE = 1'b1;
  localparam logic STOP        = 1'b1;
  localparam logic NO_STOP     = 1'b0;

  // bit0 pc, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; a stalled stage holds everything upstream
  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXCTYPE_NONE = 32'h00000000;
  localparam logic [31:0] EXCTYPE_ERET = 32'h0000000e;

  typedef enum logic {
    CTRL_RUN     = 1'b0,
    CTRL_RECOVER = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_stall_prio_enc.sv
// rtl/pipe_ctrl_stall_prio_enc.sv - strict-priority merge of per-stage stall requests
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic       req_if,
  input  logic       req_id,
  input  logic       req_ex,
  input  logic       req_mem,
  output logic [5:0] stall
);

  always_comb begin
    stall = STALL_NONE;
    if (req_mem)      stall = STALL_MEM;
    else if (req_ex)  stall = STALL_EX;
    else if (req_id)  stall = STALL_ID;
    else if (req_if)  stall = STALL_IF;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline controller: stall merge, exception/ERET flush sequencing, stall counter and watchdog
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = 32'h00000020,
  parameter int          STALL_TIMEOUT = 1024,
  parameter int          CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             stall_timeout,
  output logic             busy_recover
);

  localparam int RUN_W = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_TIMEOUT - 1);

  ctrl_state_t      state, state_nxt;
  logic [5:0]       prio_stall;
  logic [RUN_W-1:0] run_len;

  stall_prio_enc u_prio (
    .req_if  (stallreq_from_if),
    .req_id  (stallreq_from_id),
    .req_ex  (stallreq_from_ex),
    .req_mem (stallreq_from_mem),
    .stall   (prio_stall)
  );

  // Mealy outputs so the pipeline registers act on the same edge the request is seen
  always_comb begin
    state_nxt    = state;
    stall        = STALL_NONE;
    flush        = 1'b0;
    new_pc       = 32'h0;
    busy_recover = 1'b0;
    if (rst != RST_ENABLE) begin
      case (state)
        CTRL_RUN: begin
          if (excepttype_i != EXCTYPE_NONE) begin
            flush     = 1'b1;
            new_pc    = (excepttype_i == EXCTYPE_ERET) ? cp0_epc_i : EXC_VECTOR;
            state_nxt = CTRL_RECOVER;
          end else begin
            stall = prio_stall;
          end
        end
        // MEM still carries flushed state here, so its exception and stall requests are stale
        CTRL_RECOVER: begin
          busy_recover = 1'b1;
          state_nxt    = CTRL_RUN;
        end
        default: state_nxt = CTRL_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state         <= CTRL_RUN;
      stall_cycles  <= '0;
      stall_timeout <= 1'b0;
      run_len       <= '0;
    end else begin
      state <= state_nxt;
      if (stall != STALL_NONE && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (stall == STALL_NONE || flush)
        run_len <= '0;
      else if (run_len != RUN_LAST)
        run_len <= run_len + RUN_W'(1);
      if (stall != STALL_NONE && run_len == RUN_LAST)
        stall_timeout <= 1'b1;
    end
  end

  always_comb begin
    assert (!(flush && stall != STALL_NONE));
    assert ((stall & (stall + 6'd1)) == 6'd0);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector bench for pipe_ctrl
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_if, r_id, r_ex, r_mem;
  logic [31:0] exc, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic        stall_timeout;
  logic        busy_recover;

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(
    .EXC_VECTOR    (32'h00000020),
    .STALL_TIMEOUT (8),
    .CNT_W         (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_if  (r_if),
    .stallreq_from_id  (r_id),
    .stallreq_from_ex  (r_ex),
    .stallreq_from_mem (r_mem),
    .excepttype_i      (exc),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cycles      (stall_cycles),
    .stall_timeout     (stall_timeout),
    .busy_recover      (busy_recover)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;      // {mem, ex, id, if}
    logic [31:0] exc;
    logic [31:0] epc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_new_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] req, input logic [31:0] e, input logic [31:0] p);
    {r_mem, r_ex, r_id, r_if} = req;
    exc = e;
    epc = p;
  endtask

  // advance one edge, then leave inputs settled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cycles(input int n, input logic [3:0] req);
    for (int i = 0; i < n; i++) begin
      drive(req, 32'h0, 32'h0);
      step();
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    drive(4'b0000, 32'h0, 32'h0);
    for (int i = 0; i < n; i++) step();
    rst = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{4'b1111, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        1'b0};
    vecs[1]  = '{4'b0111, 32'h0, 32'h0,        6'b001111, 1'b0, 32'h0,        1'b0};
    vecs[2]  = '{4'b0011, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0};
    vecs[3]  = '{4'b0001, 32'h0, 32'h0,        6'b000011, 1'b0, 32'h0,        1'b0};
    vecs[4]  = '{4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b0};
    vecs[5]  = '{4'b0100, 32'h8, 32'h0,        6'b000000, 1'b1, 32'h20,       1'b0};
    vecs[6]  = '{4'b0000, 32'h8, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b1};
    vecs[7]  = '{4'b0000, 32'h8, 32'h0,        6'b000000, 1'b1, 32'h20,       1'b0};
    vecs[8]  = '{4'b1000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b1};
    vecs[9]  = '{4'b0000, 32'he, 32'hBFC00100, 6'b000000, 1'b1, 32'hBFC00100, 1'b0};
    vecs[10] = '{4'b0000, 32'h0, 32'h0,        6'b000000, 1'b0, 32'h0,        1'b1};
    vecs[11] = '{4'b0010, 32'h0, 32'h0,        6'b000111, 1'b0, 32'h0,        1'b0};
    vecs[12] = '{4'b1001, 32'h0, 32'h0,        6'b011111, 1'b0, 32'h0,        1'b0};

    rst = 1'b0;
    drive(4'b1111, 32'h8, 32'h12345678);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stall", 32'(stall), 32'h0);
      chk("rst_flush", 32'(flush), 32'h0);
      chk("rst_new_pc", new_pc, 32'h0);
      chk("rst_busy", 32'(busy_recover), 32'h0);
      step();
    end
    chk("rst_cycles", stall_cycles, 32'h0);
    chk("rst_timeout", 32'(stall_timeout), 32'h0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].req, vecs[i].exc, vecs[i].epc);
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_flush", i), 32'(flush), 32'(vecs[i].e_flush));
      chk($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_new_pc);
      chk($sformatf("vec%0d_busy", i), 32'(busy_recover), 32'(vecs[i].e_busy));
      step();
    end
    chk("table_cycles", stall_cycles, 32'd6);

    // stall counter: 5 id + 2 idle + 3 if, then a flush that must not count
    do_reset(1);
    cycles(5, 4'b0010);
    cycles(2, 4'b0000);
    cycles(3, 4'b0001);
    chk("cnt_8", stall_cycles, 32'd8);
    drive(4'b1111, 32'h8, 32'h0);
    step();
    drive(4'b1111, 32'h0, 32'h0);
    step();
    chk("cnt_flush", stall_cycles, 32'd8);

    // watchdog: 7 stalled cycles is one short, 8 trips it
    do_reset(1);
    cycles(7, 4'b1000);
    chk("wd_7", 32'(stall_timeout), 32'h0);
    cycles(1, 4'b0000);
    cycles(7, 4'b1000);
    chk("wd_7b", 32'(stall_timeout), 32'h0);
    cycles(1, 4'b1000);
    chk("wd_8", 32'(stall_timeout), 32'h1);
    cycles(3, 4'b0000);
    chk("wd_sticky", 32'(stall_timeout), 32'h1);

    // flush breaks the stalled run
    do_reset(1);
    chk("wd_rst", 32'(stall_timeout), 32'h0);
    cycles(5, 4'b1000);
    drive(4'b1000, 32'h8, 32'h0);
    step();
    cycles(8, 4'b1000);
    chk("wd_flush_clears", 32'(stall_timeout), 32'h0);

    // reset while in RECOVER
    do_reset(1);
    cycles(3, 4'b0001);
    drive(4'b0000, 32'h8, 32'h0);
    step();
    drive(4'b1111, 32'h8, 32'h0);
    @(negedge clk);
    chk("mid_busy", 32'(busy_recover), 32'h1);
    chk("mid_cycles", stall_cycles, 32'd3);
    rst = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall), 32'h0);
    chk("mid_rst_flush", 32'(flush), 32'h0);
    chk("mid_rst_busy", 32'(busy_recover), 32'h0);
    chk("mid_rst_new_pc", new_pc, 32'h0);
    step();
    rst = 1'b1;
    drive(4'b1000, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid_after_cycles", stall_cycles, 32'd0);
    chk("mid_after_timeout", 32'(stall_timeout), 32'h0);
    chk("mid_after_busy", 32'(busy_recover), 32'h0);
    chk("mid_after_stall", 32'(stall), 32'(6'b011111));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
